serial_logic_unit: RTL
======================

# serial_logic_unit

Control and serial compute stage for the 4-bit logic processor datapath. It drives the two datapath shift registers, A and B. Each register does a synchronous load, a right shift with MSB shift-in, and exposes its LSB as Shift_Out. The block consumes both registers' Shift_Out bits, applies a selected bitwise function, and routes the result back to their shift inputs, so one Execute press performs a complete N-bit operation.

## Interface
- N, default 4: register width; number of shift cycles per operation.
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high; clock Clk.
- Execute  input  1  level request to run one operation.
- LoadA  input  1  request to load register A from switches; honoured only in IDLE.
- LoadB  input  1  request to load register B from switches; honoured only in IDLE.
- F  input  3  function select; sampled on operation start.
- R  input  2  routing select; sampled on operation start.
- A_Out  input  1  Shift_Out (LSB) of register A.
- B_Out  input  1  Shift_Out (LSB) of register B.
- Ld_A  output  1  load strobe to register A.
- Ld_B  output  1  load strobe to register B.
- Shift_En  output  1  shift enable, shared by both registers.
- A_In  output  1  shift-in bit for register A.
- B_In  output  1  shift-in bit for register B.
- Busy  output  1  high in SHIFT and HOLD.

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - Ld_A = LoadA and Ld_B = LoadB, combinational pass-through.
  - If Execute=1 and both loads are 0: latch F and R into F_q and R_q, clear the counter, go to SHIFT.
  - If a load and Execute are both asserted, the load wins and no transition occurs that cycle.
- SHIFT:
  - Shift_En=1; the counter increments each cycle.
  - After exactly N cycles with Shift_En=1, go to HOLD.
  - Ld_A and Ld_B are forced to 0; LoadA and LoadB are ignored.
- HOLD:
  - Shift_En=0, loads ignored.
  - Stay while Execute=1; go to IDLE on the first cycle Execute=0. A held button runs exactly one operation.
- Function bit f, computed from a=A_Out, b=B_Out using F_q:
  - 000 AND, 001 OR, 010 XOR, 011 constant 1.
  - 100 NAND, 101 NOR, 110 XNOR, 111 constant 0.
- Routing using R_q:
  - 00: A_In=a, B_In=b (both registers rotate and are unchanged after N shifts).
  - 01: A_In=a, B_In=f.
  - 10: A_In=f, B_In=b.
  - 11: A_In=b, B_In=a (swap).
- A_In and B_In are combinational from a, b, F_q and R_q. They are valid in every state, and only consumed when Shift_En=1.
- F and R changes during SHIFT or HOLD have no effect on the operation in progress.

## Timing
- Reset values: state IDLE, counter 0, F_q=000, R_q=00. Shift_En=0, Busy=0, Ld_A=Ld_B=0 (assuming LoadA and LoadB are low).
- Start latency: Execute seen high in IDLE at edge k → Shift_En=1 in cycles k+1 through k+N.
- Shift_En is 0 again in cycle k+N+1 (HOLD).
- Bit order: LSBs first. After the N-th shift, each destination register holds the full N-bit result, with bit i computed from operand bit i.
- Reset asserted mid-SHIFT: next cycle is IDLE with Shift_En=0 and the counter cleared. Register contents are left partially shifted; the datapath's own reset clears them.
- Counter width is $clog2(N+1); it never wraps within an operation.

## Structure
- Package serial_logic_pkg holds:
  - the state enum (IDLE, SHIFT, HOLD);
  - F codes as named localparams (FN_AND … FN_ZERO);
  - R codes (RT_HOLD, RT_B_GETS_F, RT_A_GETS_F, RT_SWAP).
- One combinational sub-module, serial_compute_route, takes inputs a, b, F_q, R_q and produces outputs A_In, B_In, f.
- The FSM, counter, and F/R latch stay in serial_logic_unit.

## Test plan
Bench instantiates two 4-bit shift registers wired as in the datapath.

- Reset, then load A=1010 and B=0110; F=010 (XOR), R=10; pulse Execute for 2 cycles → A=1100, B=0110; Shift_En high exactly 4 cycles; Busy falls the cycle after Execute=0.
- Same operands, R=11 → A=0110, B=1010. With R=00 and any F → A and B unchanged.
- A=1100, B=1010, F=100 (NAND), R=01 → B=0111, A=1100.
- Hold Execute high for 20 cycles → exactly 4 Shift_En cycles. Change F and R during SHIFT → result matches the values latched at start. LoadA asserted during SHIFT → Ld_A stays 0.
- LoadA and Execute asserted together in IDLE → Ld_A=1 and no shift that cycle. Then with LoadA=0 and Execute=1 → operation starts on the next edge.
- Assert Reset after 2 shift cycles → next cycle IDLE, Shift_En=0, Busy=0, counter 0. A new Execute then gives a full 4-cycle run.

Source files
------------

// File: rtl/serial_logic_pkg.sv
// Shared encodings for the serial logic unit: FSM states, function codes, routing codes.
package serial_logic_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD
  } state_t;

  // Bit 2 of a function code inverts the base function selected by bits 1:0.
  localparam logic [2:0] FN_AND  = 3'b000;
  localparam logic [2:0] FN_OR   = 3'b001;
  localparam logic [2:0] FN_XOR  = 3'b010;
  localparam logic [2:0] FN_ONE  = 3'b011;
  localparam logic [2:0] FN_NAND = 3'b100;
  localparam logic [2:0] FN_NOR  = 3'b101;
  localparam logic [2:0] FN_XNOR = 3'b110;
  localparam logic [2:0] FN_ZERO = 3'b111;

  localparam logic [1:0] RT_HOLD     = 2'b00;
  localparam logic [1:0] RT_B_GETS_F = 2'b01;
  localparam logic [1:0] RT_A_GETS_F = 2'b10;
  localparam logic [1:0] RT_SWAP     = 2'b11;

endpackage

// File: rtl/serial_compute_route.sv
// Per-bit function evaluation and routing of the result back to the A/B shift inputs.
module serial_compute_route
  import serial_logic_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] F_q,
  input  logic [1:0] R_q,
  output logic       A_In,
  output logic       B_In,
  output logic       f
);

  logic base;

  always_comb begin
    base = 1'b0;
    case (F_q[1:0])
      FN_AND[1:0]: base = a & b;
      FN_OR[1:0]:  base = a | b;
      FN_XOR[1:0]: base = a ^ b;
      default:     base = 1'b1;
    endcase
  end

  assign f = base ^ F_q[2];

  always_comb begin
    A_In = a;
    B_In = b;
    case (R_q)
      RT_HOLD: begin
        A_In = a;
        B_In = b;
      end
      RT_B_GETS_F: begin
        A_In = a;
        B_In = f;
      end
      RT_A_GETS_F: begin
        A_In = f;
        B_In = b;
      end
      default: begin
        A_In = b;
        B_In = a;
      end
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Control FSM for the serial logic processor: loads, N-cycle shift run, and hold-until-release.
module serial_logic_unit
  import serial_logic_pkg::*;
#(
  parameter int N = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Execute,
  input  logic          LoadA,
  input  logic          LoadB,
  input  logic [2:0]    F,
  input  logic [1:0]    R,
  input  logic          A_Out,
  input  logic          B_Out,
  output logic          Ld_A,
  output logic          Ld_B,
  output logic          Shift_En,
  output logic          A_In,
  output logic          B_In,
  output logic          Busy,
  output state_t        Dbg_State,
  output logic [CW-1:0] Dbg_Count
);

  // Handshake: Execute is a level request accepted in IDLE when no load is
  // pending; Busy stays high from acceptance until Execute has been released
  // after the run, so one press (however long) yields exactly one operation.
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f_sel_q;
  logic [1:0]    r_sel_q;
  logic          start;
  logic          f_bit;

  assign start = (state_q == IDLE) && Execute && !LoadA && !LoadB;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (!Execute) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_sel_q <= 3'b000;
      r_sel_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        f_sel_q <= F;
        r_sel_q <= R;
      end
    end
  end

  assign Ld_A      = (state_q == IDLE) && LoadA;
  assign Ld_B      = (state_q == IDLE) && LoadB;
  assign Shift_En  = (state_q == SHIFT);
  assign Busy      = (state_q != IDLE);
  assign Dbg_State = state_q;
  assign Dbg_Count = cnt_q;

  serial_compute_route u_route (
    .a    (A_Out),
    .b    (B_Out),
    .F_q  (f_sel_q),
    .R_q  (r_sel_q),
    .A_In (A_In),
    .B_In (B_In),
    .f    (f_bit)
  );

endmodule
